mac_dst_lookup: RTL and testbench
=================================

# mac_dst_lookup

Destination-side reader of the MAC learning table. Parses the destination MAC address from the ingress byte stream and derives the table slot from its low 14 bits. It reads the learned egress port and remaining age through a synchronous read port, then issues one forwarding decision per frame: unicast to a port, flood, or drop. It sits between the ingress frame parser and the egress port arbiter, alongside the table writer that learns source addresses.

## Interface
Parameters:
- pADRESS, 2, width of a port number
- pSLOTS, 16384, table depth; slot index width is $clog2(pSLOTS) = 14
- pDATA_WIDTH, 8, stream byte width
- pTIME, 9, width of the age field read from the table

Ports:
- iclk  in  1  clock
- irst  in  1  reset, asynchronous, active-high
- irx_d  in  pDATA_WIDTH  frame byte
- irx_dv  in  1  irx_d valid this cycle
- i_sof  in  1  with irx_dv, marks first destination MAC byte
- i_eof  in  1  with irx_dv, marks last frame byte
- i_port_num  in  pADRESS  ingress port of the current frame, stable from i_sof to o_valid
- o_rd_en  out  1  table read strobe, one-cycle pulse
- o_rd_addr  out  $clog2(pSLOTS)  table slot
- i_rd_port  in  pADRESS  learned port, valid one cycle after o_rd_en
- i_rd_time  in  pTIME  remaining age, valid one cycle after o_rd_en; 0 = expired
- o_valid  out  1  decision strobe, one-cycle pulse
- o_port_num  out  pADRESS  egress port when unicast
- o_flood  out  1  send to all ports except ingress
- o_drop  out  1  discard frame

## Operation
- FSM states: IDLE, CAPT, READ, WAIT, DECIDE.
- IDLE: on irx_dv & i_sof, capture byte 0 and go to CAPT with byte count 1.
- CAPT: each irx_dv byte is captured into the 48-bit destination register, bytes 0..5 in MSB-first order.
  - Cycles with irx_dv low are ignored.
  - When byte 5 is accepted, go to READ.
  - i_eof before byte 5 (runt frame): return to IDLE with no o_valid.
- READ: drive o_rd_en=1 and o_rd_addr={byte4[5:0], byte5}, then go to WAIT.
- WAIT: table data is returned; go to DECIDE.
- DECIDE: register the decision, pulse o_valid, return to IDLE. Priority order:
  1. Destination broadcast (all FF) or multicast (byte0[0]=1): o_flood=1.
  2. Otherwise, if i_rd_time==0 (expired or never learned): o_flood=1.
  3. Otherwise, if i_rd_port==i_port_num: o_drop=1 (filter).
  4. Otherwise: unicast, o_port_num=i_rd_port, o_flood=0, o_drop=0.
- Flag rules:
  - o_flood and o_drop are never both 1.
  - o_port_num is 0 whenever o_flood or o_drop is 1.
  - Flags and port hold their values after o_valid until the next o_valid.
- Bytes after byte 5 are ignored until the next i_sof.
- i_sof while in CAPT/READ/WAIT: abandon the frame in flight (no o_valid) and restart capture with that byte as byte 0. DECIDE always completes.
- No table writes are issued. The writer's same-cycle write to the same slot is not forwarded; the old value is used.

## Timing
- Byte 5 accepted at cycle N: o_rd_en=1 at N+1, i_rd_* sampled at N+2, o_valid=1 at N+3. Fixed latency of 3 cycles from last MAC byte.
- Earliest next i_sof is accepted at N+3 (IDLE re-entered the same cycle o_valid pulses, so back-to-back frames are possible).
- Reset values: o_rd_en=0, o_rd_addr=0, o_valid=0, o_port_num=0, o_flood=0, o_drop=0; FSM in IDLE, byte count 0.
- Reset asserted mid-frame clears all state immediately. The frame is lost and no o_valid is generated after release.

## Configuration
- MAC_DST_LOOKUP_FILTER_EN defined: rule 3 is active; same-port hits give o_drop=1.
- Undefined: rule 3 is removed; a same-port hit is unicast to i_rd_port, and o_drop is tied to 0.

## Structure
- Shared package mac_pkg holds:
  - the default values of pADRESS, pSLOTS, pTIME and pDATA_WIDTH
  - the FSM state enum
  - the broadcast constant 48'hFFFF_FFFF_FFFF
  - the slot-index function (low 14 bits of the MAC)
- One sub-module, mac_dst_capture. It contains the byte counter and the 48-bit shift register, and reports done/runt.

## Test plan
- Unicast hit: dst 00:11:22:33:01:05, ingress 0, table slot 0x105 = {port 2, time 300} -> o_rd_addr=0x105 at N+1; o_valid at N+3 with o_port_num=2, o_flood=0, o_drop=0.
- Broadcast: dst FF:FF:FF:FF:FF:FF, any table contents -> o_flood=1 at N+3, o_port_num=0.
- Expired entry: slot time=0, port 3 -> o_flood=1. Same frame with multicast dst 01:00:5E:00:00:01 -> o_flood=1.
- Same-port hit: slot = {port 1, time 5}, ingress 1 -> o_drop=1 with macro defined; o_port_num=1 and o_drop=0 with macro undefined.
- Gaps and runt: irx_dv low for 2 cycles between bytes 2 and 3 -> o_valid delayed by exactly 2 cycles. i_eof on byte 3 -> no o_rd_en, no o_valid.
- Restart/reset: new i_sof in WAIT -> old result suppressed, new frame decided correctly. irst pulsed in CAPT -> all outputs 0, no o_valid.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC learning table readers/writers:
// default widths, lookup FSM states, the broadcast address and the
// MAC-to-slot hash (low bits of the address).
package mac_pkg;

  localparam int MAC_ADRESS_W = 2;
  localparam int MAC_SLOTS    = 16384;
  localparam int MAC_DATA_W   = 8;
  localparam int MAC_TIME_W   = 9;
  localparam int MAC_SLOT_W   = $clog2(MAC_SLOTS);

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    READ,
    WAIT,
    DECIDE
  } state_t;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  // Table slot is simply the low bits of the address, i.e. {byte4[5:0], byte5}.
  function automatic logic [MAC_SLOT_W-1:0] mac_slot(input logic [47:0] mac);
    return mac[MAC_SLOT_W-1:0];
  endfunction

endpackage

// File: rtl/mac_dst_capture.sv
// Destination MAC capture: byte counter plus 48-bit MSB-first shift register.
// start loads byte 0, shift appends the next byte; done flags byte 5,
// runt flags an end-of-frame before byte 5.
module mac_dst_capture
  import mac_pkg::*;
#(
  parameter int pDATA_WIDTH = MAC_DATA_W
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   start,
  input  logic                   shift,
  input  logic                   last,
  input  logic [pDATA_WIDTH-1:0] data,
  output logic [47:0]            mac,
  output logic                   done,
  output logic                   runt
);

  logic [2:0] count;

  assign done = shift && (count == 3'd5);
  assign runt = (start || shift) && last && !done;

  // Load byte 0 on start, shift in later bytes, clear the count when the frame ends
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      count <= 3'd0;
      mac   <= '0;
    end else if (start) begin
      count <= runt ? 3'd0 : 3'd1;
      mac   <= {{(48-pDATA_WIDTH){1'b0}}, data};
    end else if (shift) begin
      count <= (done || runt) ? 3'd0 : count + 3'd1;
      mac   <= {mac[47-pDATA_WIDTH:0], data};
    end
  end

endmodule

// File: rtl/mac_dst_lookup.sv
// Destination lookup: captures the destination MAC, reads the learned
// port/age from the table and issues one unicast/flood/drop decision per frame.
// Build option MAC_DST_LOOKUP_FILTER_EN: when defined, a hit on the ingress
// port itself is dropped; otherwise it is unicast back and o_drop stays 0.
module mac_dst_lookup
  import mac_pkg::*;
#(
  parameter int pADRESS     = MAC_ADRESS_W,
  parameter int pSLOTS      = MAC_SLOTS,
  parameter int pDATA_WIDTH = MAC_DATA_W,
  parameter int pTIME       = MAC_TIME_W
) (
  input  logic                       iclk,
  input  logic                       irst,
  input  logic [pDATA_WIDTH-1:0]     irx_d,
  input  logic                       irx_dv,
  input  logic                       i_sof,
  input  logic                       i_eof,
  input  logic [pADRESS-1:0]         i_port_num,
  output logic                       o_rd_en,
  output logic [$clog2(pSLOTS)-1:0]  o_rd_addr,
  input  logic [pADRESS-1:0]         i_rd_port,
  input  logic [pTIME-1:0]           i_rd_time,
  output logic                       o_valid,
  output logic [pADRESS-1:0]         o_port_num,
  output logic                       o_flood,
  output logic                       o_drop
);

  localparam int SLOT_W = $clog2(pSLOTS);

  state_t              state;
  state_t              next_state;
  logic                start;
  logic                shift;
  logic                commit;
  logic [47:0]         cap_mac;
  logic                cap_done;
  logic                cap_runt;
  logic                dec_flood;
  logic [pADRESS-1:0]  dec_port;
`ifdef MAC_DST_LOOKUP_FILTER_EN
  logic                dec_drop;
`else
  logic                unused_port;
  assign unused_port = ^i_port_num;
`endif

  // A start-of-frame byte always restarts capture, whatever the state
  assign start  = irx_dv && i_sof;
  assign shift  = (state == CAPT) && irx_dv && !i_sof;
  assign commit = (state == WAIT) && !start;
  assign o_rd_en = (state == READ);

  mac_dst_capture #(
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_capture (
    .iclk  (iclk),
    .irst  (irst),
    .start (start),
    .shift (shift),
    .last  (i_eof),
    .data  (irx_d),
    .mac   (cap_mac),
    .done  (cap_done),
    .runt  (cap_runt)
  );

  // Next-state logic; a new frame pre-empts everything, DECIDE still emits its result
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = cap_runt ? IDLE : CAPT;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        CAPT:    if (cap_done) next_state = READ;
                 else if (cap_runt) next_state = IDLE;
        READ:    next_state = WAIT;
        WAIT:    next_state = DECIDE;
        DECIDE:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Forwarding decision from the captured address and the table read data
  always_comb begin
    dec_flood = 1'b0;
    dec_port  = '0;
`ifdef MAC_DST_LOOKUP_FILTER_EN
    dec_drop  = 1'b0;
`endif
    if ((cap_mac == MAC_BCAST) || cap_mac[40]) begin
      dec_flood = 1'b1;
    end else if (i_rd_time == '0) begin
      dec_flood = 1'b1;
`ifdef MAC_DST_LOOKUP_FILTER_EN
    end else if (i_rd_port == i_port_num) begin
      dec_drop = 1'b1;
`endif
    end else begin
      dec_port = i_rd_port;
    end
  end

  // State register
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Read address latched with byte 5; decision latched at the end of WAIT and held
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      o_rd_addr  <= '0;
      o_valid    <= 1'b0;
      o_port_num <= '0;
      o_flood    <= 1'b0;
`ifdef MAC_DST_LOOKUP_FILTER_EN
      o_drop     <= 1'b0;
`endif
    end else begin
      o_valid <= commit;
      if (cap_done) begin
        o_rd_addr <= SLOT_W'(mac_slot({cap_mac[47-pDATA_WIDTH:0], irx_d}));
      end
      if (commit) begin
        o_port_num <= dec_port;
        o_flood    <= dec_flood;
`ifdef MAC_DST_LOOKUP_FILTER_EN
        o_drop     <= dec_drop;
`endif
      end
    end
  end

`ifndef MAC_DST_LOOKUP_FILTER_EN
  assign o_drop = 1'b0;
`endif

endmodule

// File: tb/tb_mac_dst_lookup.sv
// Bench for mac_dst_lookup: directed frames followed by random frames, with a
// table memory model and a decision model computed from the forwarding rules.
module tb_mac_dst_lookup;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic [7:0]  irx_d = 8'd0;
  logic        irx_dv = 1'b0;
  logic        i_sof = 1'b0;
  logic        i_eof = 1'b0;
  logic [1:0]  i_port_num = 2'd0;
  logic        o_rd_en;
  logic [13:0] o_rd_addr;
  logic [1:0]  i_rd_port = 2'd0;
  logic [8:0]  i_rd_time = 9'd0;
  logic        o_valid;
  logic [1:0]  o_port_num;
  logic        o_flood;
  logic        o_drop;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int flag_viol = 0;

  logic [1:0] tbl_port [0:16383];
  logic [8:0] tbl_time [0:16383];

  int         rd_q_cyc[$];
  logic [13:0] rd_q_addr[$];
  int         v_q_cyc[$];
  logic [3:0] v_q_dec[$];

  mac_dst_lookup dut (
    .iclk       (iclk),
    .irst       (irst),
    .irx_d      (irx_d),
    .irx_dv     (irx_dv),
    .i_sof      (i_sof),
    .i_eof      (i_eof),
    .i_port_num (i_port_num),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_port  (i_rd_port),
    .i_rd_time  (i_rd_time),
    .o_valid    (o_valid),
    .o_port_num (o_port_num),
    .o_flood    (o_flood),
    .o_drop     (o_drop)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc <= cyc + 1;

  // Synchronous-read table: data valid only in the cycle after the strobe
  always @(posedge iclk) begin
    if (o_rd_en) begin
      i_rd_port <= tbl_port[o_rd_addr];
      i_rd_time <= tbl_time[o_rd_addr];
    end else begin
      i_rd_port <= 2'($urandom());
      i_rd_time <= 9'($urandom());
    end
  end

  // Output monitor on the falling edge
  always @(negedge iclk) begin
    if (o_rd_en === 1'b1) begin
      rd_q_cyc.push_back(cyc);
      rd_q_addr.push_back(o_rd_addr);
    end
    if (o_valid === 1'b1) begin
      v_q_cyc.push_back(cyc);
      v_q_dec.push_back({o_flood, o_drop, o_port_num});
    end
    if (o_flood === 1'b1 && o_drop === 1'b1) flag_viol++;
    if ((o_flood === 1'b1 || o_drop === 1'b1) && o_port_num !== 2'd0) flag_viol++;
  end

  // Expected decision {flood, drop, port} from the forwarding rules
  function automatic logic [3:0] model(input logic [47:0] mac, input logic [1:0] inport,
                                       input logic [1:0] p, input logic [8:0] t);
    if (mac == 48'hFFFF_FFFF_FFFF) return 4'b1000;
    if (mac[40]) return 4'b1000;
    if (t == 9'd0) return 4'b1000;
`ifdef MAC_DST_LOOKUP_FILTER_EN
    if (p == inport) return 4'b0100;
`endif
    return {2'b00, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic sof, input logic eof);
    @(posedge iclk); #1;
    irx_dv = 1'b1; irx_d = b; i_sof = sof; i_eof = eof;
  endtask

  task automatic idle_cycle();
    @(posedge iclk); #1;
    irx_dv = 1'b0; irx_d = 8'($urandom()); i_sof = 1'b0; i_eof = 1'b0;
  endtask

  // Sends one frame; first/last report the cycles of byte 0 and of the final MAC byte
  task automatic send_frame(input logic [47:0] mac, input int gap_after, input int gap_len,
                            input int eof_at, input int trail, output int first, output int last);
    first = 0; last = 0;
    for (int i = 0; i < 6; i++) begin
      drive_byte(mac[47-8*i -: 8], i == 0, (i == eof_at) || (i == 5 && trail == 0));
      if (i == 0) first = cyc;
      last = cyc;
      if (i == eof_at) break;
      if (i == gap_after) repeat (gap_len) idle_cycle();
    end
    if (eof_at > 5) begin
      for (int k = 0; k < trail; k++) drive_byte(8'($urandom()), 1'b0, k == trail - 1);
    end
    idle_cycle();
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic set_slot(input logic [13:0] a, input logic [1:0] p, input logic [8:0] t);
    tbl_port[a] = p;
    tbl_time[a] = t;
  endtask

  // One read at n+1 to addr and one decision at n+3 equal to dec
  task automatic expect_frame(input string tag, input int n, input logic [13:0] addr,
                              input logic [3:0] dec);
    int nr, nv;
    wait_until(n + 5);
    nr = rd_q_cyc.size();
    nv = v_q_cyc.size();
    chk({tag, ".nrd"}, 64'(nr), 64'(1));
    chk({tag, ".nvalid"}, 64'(nv), 64'(1));
    if (nr > 0) begin
      chk({tag, ".rdcyc"}, 64'(rd_q_cyc.pop_front()), 64'(n + 1));
      chk({tag, ".rdaddr"}, 64'(rd_q_addr.pop_front()), 64'(addr));
    end
    if (nv > 0) begin
      chk({tag, ".vcyc"}, 64'(v_q_cyc.pop_front()), 64'(n + 3));
      chk({tag, ".dec"}, 64'(v_q_dec.pop_front()), 64'(dec));
    end
    rd_q_cyc.delete(); rd_q_addr.delete(); v_q_cyc.delete(); v_q_dec.delete();
  endtask

  initial begin
    int s, n, na, nb;
    logic [47:0] m;
    logic [1:0]  p, inp;
    logic [8:0]  t;
    logic [3:0]  exp_dec;

    for (int a = 0; a < 16384; a++) begin
      tbl_port[a] = 2'($urandom());
      tbl_time[a] = 9'($urandom_range(1, 511));
    end

    // Reset state
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("rst.rd_en", 64'(o_rd_en), 64'(0));
    chk("rst.rd_addr", 64'(o_rd_addr), 64'(0));
    chk("rst.valid", 64'(o_valid), 64'(0));
    chk("rst.port", 64'(o_port_num), 64'(0));
    chk("rst.flood", 64'(o_flood), 64'(0));
    chk("rst.drop", 64'(o_drop), 64'(0));
    @(posedge iclk); #1;
    irst = 1'b0;
    rd_q_cyc.delete(); rd_q_addr.delete(); v_q_cyc.delete(); v_q_dec.delete();

    // Unicast hit
    set_slot(14'h105, 2'd2, 9'd300);
    i_port_num = 2'd0;
    send_frame(48'h0011_2233_0105, -1, 0, 99, 0, s, n);
    expect_frame("ucast", n, 14'h105, 4'b0010);
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("hold.port", 64'(o_port_num), 64'(2));
    chk("hold.flood", 64'(o_flood), 64'(0));
    chk("hold.valid", 64'(o_valid), 64'(0));

    // Broadcast
    set_slot(14'h3FFF, 2'd1, 9'd77);
    i_port_num = 2'd3;
    send_frame(48'hFFFF_FFFF_FFFF, -1, 0, 99, 0, s, n);
    expect_frame("bcast", n, 14'h3FFF, 4'b1000);

    // Expired entry, then multicast destination
    set_slot(14'h0A0B & 14'h3FFF, 2'd3, 9'd0);
    i_port_num = 2'd0;
    send_frame(48'h0022_4466_0A0B, -1, 0, 99, 0, s, n);
    expect_frame("expired", n, 14'h0A0B, 4'b1000);
    set_slot(14'h0001, 2'd3, 9'd100);
    send_frame(48'h0100_5E00_0001, -1, 0, 99, 0, s, n);
    expect_frame("mcast", n, 14'h0001, 4'b1000);

    // Same-port hit
    set_slot(14'h0234, 2'd1, 9'd5);
    i_port_num = 2'd1;
    send_frame(48'h0A0B_0C0D_4234, -1, 0, 99, 0, s, n);
`ifdef MAC_DST_LOOKUP_FILTER_EN
    exp_dec = 4'b0100;
`else
    exp_dec = 4'b0001;
`endif
    expect_frame("sameport", n, 14'h0234, exp_dec);

    // Gap of two idle cycles between bytes 2 and 3
    set_slot(14'h0777, 2'd3, 9'd9);
    i_port_num = 2'd0;
    send_frame(48'h0012_3456_0777, 2, 2, 99, 0, s, n);
    chk("gap.span", 64'(n - s), 64'(7));
    expect_frame("gap", n, 14'h0777, 4'b0011);

    // Runt: end of frame on byte 3
    send_frame(48'h0012_3456_0777, -1, 0, 3, 0, s, n);
    wait_until(n + 6);
    chk("runt.nrd", 64'(rd_q_cyc.size()), 64'(0));
    chk("runt.nvalid", 64'(v_q_cyc.size()), 64'(0));

    // Restart in WAIT: A's decision suppressed, B decided
    set_slot(14'h0111, 2'd3, 9'd50);
    set_slot(14'h0222, 2'd2, 9'd60);
    i_port_num = 2'd0;
    send_frame(48'h0000_0000_0111, -1, 0, 99, 0, s, na);
    send_frame(48'h0000_0000_0222, -1, 0, 99, 0, s, nb);
    chk("restart.bstart", 64'(s), 64'(na + 2));
    wait_until(nb + 5);
    chk("restart.nrd", 64'(rd_q_cyc.size()), 64'(2));
    chk("restart.nvalid", 64'(v_q_cyc.size()), 64'(1));
    if (v_q_cyc.size() > 0) begin
      chk("restart.vcyc", 64'(v_q_cyc.pop_front()), 64'(nb + 3));
      chk("restart.dec", 64'(v_q_dec.pop_front()), 64'(4'b0010));
    end
    rd_q_cyc.delete(); rd_q_addr.delete(); v_q_cyc.delete(); v_q_dec.delete();

    // Back-to-back: next sof in the cycle the decision pulses
    set_slot(14'h0333, 2'd1, 9'd70);
    send_frame(48'h0000_0000_0111, -1, 0, 99, 0, s, na);
    idle_cycle();
    send_frame(48'h0000_0000_0333, -1, 0, 99, 0, s, nb);
    chk("b2b.bstart", 64'(s), 64'(na + 3));
    wait_until(nb + 5);
    chk("b2b.nvalid", 64'(v_q_cyc.size()), 64'(2));
    if (v_q_cyc.size() == 2) begin
      chk("b2b.a.vcyc", 64'(v_q_cyc.pop_front()), 64'(na + 3));
      chk("b2b.a.dec", 64'(v_q_dec.pop_front()), 64'(4'b0011));
      chk("b2b.b.vcyc", 64'(v_q_cyc.pop_front()), 64'(nb + 3));
      chk("b2b.b.dec", 64'(v_q_dec.pop_front()), 64'(4'b0001));
    end
    rd_q_cyc.delete(); rd_q_addr.delete(); v_q_cyc.delete(); v_q_dec.delete();

    // Reset pulsed during capture
    drive_byte(8'h00, 1'b1, 1'b0);
    drive_byte(8'h00, 1'b0, 1'b0);
    drive_byte(8'h00, 1'b0, 1'b0);
    #1 irst = 1'b1;
    @(negedge iclk);
    chk("midrst.rd_en", 64'(o_rd_en), 64'(0));
    chk("midrst.rd_addr", 64'(o_rd_addr), 64'(0));
    chk("midrst.valid", 64'(o_valid), 64'(0));
    chk("midrst.port", 64'(o_port_num), 64'(0));
    chk("midrst.flood", 64'(o_flood), 64'(0));
    chk("midrst.drop", 64'(o_drop), 64'(0));
    @(posedge iclk); #1;
    irst = 1'b0;
    drive_byte(8'h00, 1'b0, 1'b0);
    drive_byte(8'h03, 1'b0, 1'b0);
    drive_byte(8'h33, 1'b0, 1'b1);
    idle_cycle();
    n = cyc;
    wait_until(n + 6);
    chk("midrst.nrd", 64'(rd_q_cyc.size()), 64'(0));
    chk("midrst.nvalid", 64'(v_q_cyc.size()), 64'(0));
    rd_q_cyc.delete(); rd_q_addr.delete(); v_q_cyc.delete(); v_q_dec.delete();

    // Random frames
    for (int r = 0; r < 24; r++) begin
      m[31:0]  = $urandom();
      m[47:32] = 16'($urandom());
      m[40]    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) m = 48'hFFFF_FFFF_FFFF;
      inp = 2'($urandom());
      p   = ($urandom_range(0, 2) == 0) ? inp : 2'($urandom());
      t   = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      set_slot(m[13:0], p, t);
      i_port_num = inp;
      send_frame(m, $urandom_range(0, 4), $urandom_range(0, 2), 99, $urandom_range(0, 2), s, n);
      expect_frame($sformatf("rand%0d", r), n, m[13:0], model(m, inp, p, t));
    end

    chk("flag.rules", 64'(flag_viol), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
